// File: rtl/busint_apb.sv
// -----------------------------------------------------------------------------
// busint_apb - parametrised APB3 slave register interface for the USRT.
//
// Decodes a word address into NUM_REGS control registers. It provides the
// PREADY/PSLVERR handshake and one-cycle read/write strobes for the TX, RX
// and baud blocks.
//
// Optional build macro: BUSINT_WAIT_EN
//   defined   : every access inserts WAIT_CYCLES wait states (o_Pready=0)
//               before the ready cycle.
//   undefined : the wait counter is compiled out; o_Pready rises in the first
//               ACCESS cycle and WAIT_CYCLES has no effect.
//
// Ports:
//   i_Pclk      in   APB clock, all state on rising edge
//   i_Preset    in   synchronous active-high reset
//   i_Paddr     in   word address (latched in SETUP)
//   i_Psel      in   slave select
//   i_Penable   in   access phase
//   i_Pwrite    in   1=write / 0=read (latched in SETUP)
//   i_Pwdata    in   write data (latched in SETUP)
//   o_Prdata    out  read data during a ready read cycle, else 0
//   o_Pready    out  transfer complete
//   o_Pslverr   out  address out of range (only together with o_Pready)
//   o_WrStrobe  out  one-hot pulse the cycle after a completed write
//   o_RdStrobe  out  one-hot pulse the cycle after a completed read
//   o_RegFlat   out  register k at bits [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module busint_apb #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       i_Pclk,
  input  logic                       i_Preset,
  input  logic [ADDR_W-1:0]          i_Paddr,
  input  logic                       i_Psel,
  input  logic                       i_Penable,
  input  logic                       i_Pwrite,
  input  logic [DATA_W-1:0]          i_Pwdata,
  output logic [DATA_W-1:0]          o_Prdata,
  output logic                       o_Pready,
  output logic                       o_Pslverr,
  output logic [NUM_REGS-1:0]        o_WrStrobe,
  output logic [NUM_REGS-1:0]        o_RdStrobe,
  output logic [NUM_REGS*DATA_W-1:0] o_RegFlat
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
    $error("busint_apb: NUM_REGS out of range");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("busint_apb: WAIT_CYCLES out of range");
  end

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   reg_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic [NUM_REGS-1:0] rd_strobe_q, rd_strobe_d;

  logic [NUM_REGS-1:0] sel_onehot;  // decode of the latched address
  logic                addr_valid;
  logic                cnt_zero;
  logic                pready;
  logic [DATA_W-1:0]   rdata;

`ifdef BUSINT_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
  assign cnt_zero = (cnt_q == 4'd0);
`else
  assign cnt_zero = 1'b1;
`endif

  // Address decode: an out-of-range address leaves sel_onehot all-zero, which
  // automatically suppresses register writes, strobes and read data.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    assign sel_onehot[gi] = (addr_q == ADDR_W'(gi));
  end
  assign addr_valid = |sel_onehot;

  assign pready    = (state_q == S_ACCESS) & i_Psel & i_Penable & cnt_zero;
  assign o_Pready  = pready;
  assign o_Pslverr = pready & ~addr_valid;

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (pready && !write_q && sel_onehot[k]) begin
        rdata = reg_q[k];
      end
    end
  end
  assign o_Prdata = rdata;

  // Next-state / control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wr_strobe_d = '0;
    rd_strobe_d = '0;
`ifdef BUSINT_WAIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // PSEL with PENABLE while idle is a protocol error and is ignored.
        if (i_Psel && !i_Penable) begin
          addr_d  = i_Paddr;
          write_d = i_Pwrite;
          wdata_d = i_Pwdata;
`ifdef BUSINT_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!i_Psel) begin
          // Master withdrew before completion: abort silently.
          state_d = S_IDLE;
        end else if (i_Penable) begin
          if (cnt_zero) begin
            state_d = S_IDLE;
            if (write_q) begin
              wr_strobe_d = sel_onehot;
            end else begin
              rd_strobe_d = sel_onehot;
            end
          end else begin
`ifdef BUSINT_WAIT_EN
            cnt_d = cnt_q - 4'd1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Preset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
`ifdef BUSINT_WAIT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
`ifdef BUSINT_WAIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Register file: each register updates only on a completed, decoded write.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_comb begin
      reg_d[gi] = reg_q[gi];
      if (pready && write_q && sel_onehot[gi]) begin
        reg_d[gi] = wdata_q;
      end
    end

    always_ff @(posedge i_Pclk) begin
      if (i_Preset) begin
        reg_q[gi] <= '0;
      end else begin
        reg_q[gi] <= reg_d[gi];
      end
    end

    assign o_RegFlat[gi*DATA_W +: DATA_W] = reg_q[gi];
  end

  assign o_WrStrobe = wr_strobe_q;
  assign o_RdStrobe = rd_strobe_q;

endmodule

// File: tb/tb_busint_apb.sv
// -----------------------------------------------------------------------------
// tb_busint_apb - self-checking bench for busint_apb (ADDR_W=4, DATA_W=8,
// NUM_REGS=4, WAIT_CYCLES=2). Works with or without BUSINT_WAIT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_busint_apb;

`ifdef BUSINT_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic [3:0]  paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  pwdata = '0;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  wr_strobe;
  logic [3:0]  rd_strobe;
  logic [31:0] reg_flat;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of register values.
  logic [7:0] model_regs [4];

  busint_apb #(
    .ADDR_W(4), .DATA_W(8), .NUM_REGS(4), .WAIT_CYCLES(2)
  ) dut (
    .i_Pclk(clk), .i_Preset(srst), .i_Paddr(paddr), .i_Psel(psel),
    .i_Penable(penable), .i_Pwrite(pwrite), .i_Pwdata(pwdata),
    .o_Prdata(prdata), .o_Pready(pready), .o_Pslverr(pslverr),
    .o_WrStrobe(wr_strobe), .o_RdStrobe(rd_strobe), .o_RegFlat(reg_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_flat();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic logic [3:0] exp_strobe(input logic [3:0] a);
    logic [3:0] s;
    s = '0;
    if (a < 4) s[a[1:0]] = 1'b1;
    return s;
  endfunction

  // Drives SETUP then ACCESS; returns at the falling edge of the ready cycle
  // with the bus still driven, so a following call is a back-to-back transfer.
  task automatic do_xfer(input logic [3:0] a, input logic w, input logic [7:0] d,
                         output int waits, output logic err, output logic [7:0] rd);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = 4'($urandom);   // must be ignored during ACCESS
    pwdata  = 8'($urandom);
    waits = 0;
    @(negedge clk);
    while (!pready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    err = pslverr;
    rd  = prdata;
  endtask

  task automatic release_bus();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1; srst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; srst = 1'b0;
    for (int k = 0; k < 4; k++) model_regs[k] = '0;
    @(negedge clk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b exp 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", pslverr); end
    checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL reset_prdata got %h exp 00", prdata); end
    checks++; if (reg_flat !== 32'h0) begin errors++; $display("FAIL reset_regflat got %h exp 0", reg_flat); end
    checks++; if ({wr_strobe, rd_strobe} !== 8'h00) begin errors++; $display("FAIL reset_strobes got %b/%b exp 0/0", wr_strobe, rd_strobe); end
    $display("reset: regflat=%h", reg_flat);
  endtask

  task automatic test_directed();
    int waits; logic err; logic [7:0] rd;
    // write 0xA5 to addr 1
    do_xfer(4'd1, 1'b1, 8'hA5, waits, err, rd);
    model_regs[1] = 8'hA5;
    checks++; if (waits !== EXP_WAIT) begin errors++; $display("FAIL wr1_waits got %0d exp %0d", waits, EXP_WAIT); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr1_slverr got %b exp 0", err); end
    release_bus();
    checks++; if (wr_strobe !== 4'b0010) begin errors++; $display("FAIL wr1_strobe got %b exp 0010", wr_strobe); end
    checks++; if (reg_flat[15:8] !== 8'hA5) begin errors++; $display("FAIL wr1_reg got %h exp a5", reg_flat[15:8]); end
    @(negedge clk);
    checks++; if (wr_strobe !== 4'b0000) begin errors++; $display("FAIL wr1_strobe_clear got %b exp 0000", wr_strobe); end
    $display("write addr=1 data=a5 waits=%0d err=%b", waits, err);
    // read addr 1
    do_xfer(4'd1, 1'b0, 8'h00, waits, err, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd1_data got %h exp a5", rd); end
    release_bus();
    checks++; if (rd_strobe !== 4'b0010) begin errors++; $display("FAIL rd1_strobe got %b exp 0010", rd_strobe); end
    checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL rd1_prdata_after got %h exp 00", prdata); end
    $display("read  addr=1 data=%h waits=%0d err=%b", rd, waits, err);
    // write 0x3C to out-of-range addr 7
    do_xfer(4'd7, 1'b1, 8'h3C, waits, err, rd);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr7_slverr got %b exp 1", err); end
    release_bus();
    checks++; if (reg_flat !== model_flat()) begin errors++; $display("FAIL wr7_regflat got %h exp %h", reg_flat, model_flat()); end
    checks++; if ({wr_strobe, rd_strobe} !== 8'h00) begin errors++; $display("FAIL wr7_strobes got %b/%b exp 0/0", wr_strobe, rd_strobe); end
    $display("write addr=7 data=3c waits=%0d err=%b", waits, err);
  endtask

  task automatic test_random();
    int waits; logic err; logic [7:0] rd;
    logic [3:0] a; logic w; logic [7:0] d; logic valid; logic [7:0] exp_rd;
    logic b2b;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 7));
      w = 1'($urandom);
      d = 8'($urandom);
      valid  = (a < 4);
      exp_rd = (!w && valid) ? model_regs[a[1:0]] : 8'h00;
      do_xfer(a, w, d, waits, err, rd);
      if (w && valid) model_regs[a[1:0]] = d;
      checks++; if (waits !== EXP_WAIT) begin errors++; $display("FAIL rnd_waits[%0d] got %0d exp %0d", n, waits, EXP_WAIT); end
      checks++; if (err !== !valid) begin errors++; $display("FAIL rnd_slverr[%0d] got %b exp %b", n, err, !valid); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", n, rd, exp_rd); end
      b2b = 1'($urandom);
      if (!b2b || n == 39) begin
        release_bus();
        checks++;
        if (wr_strobe !== (w ? exp_strobe(a) : 4'b0) || rd_strobe !== (w ? 4'b0 : exp_strobe(a))) begin
          errors++;
          $display("FAIL rnd_strobe[%0d] got %b/%b", n, wr_strobe, rd_strobe);
        end
        checks++; if (reg_flat !== model_flat()) begin errors++; $display("FAIL rnd_regflat[%0d] got %h exp %h", n, reg_flat, model_flat()); end
      end
      $display("rnd %0d: %s addr=%0d wdata=%h rdata=%h err=%b b2b=%b", n, w ? "write" : "read ", a, d, rd, err, b2b);
    end
  endtask

  task automatic test_abort();
    int waits; logic err; logic [7:0] rd;
    do_xfer(4'd0, 1'b1, 8'h11, waits, err, rd);
    model_regs[0] = 8'h11;
    checks++; if (waits !== EXP_WAIT) begin errors++; $display("FAIL ab_waits got %0d exp %0d", waits, EXP_WAIT); end
    release_bus();
    // Abort 1: PSEL dropped right after SETUP.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 4'd0; pwrite = 1'b1; pwdata = 8'h77;
    @(posedge clk); #1; psel = 1'b0;
    @(negedge clk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL ab1_pready got %b exp 0", pready); end
    @(negedge clk);
    checks++; if ({wr_strobe, rd_strobe} !== 8'h00) begin errors++; $display("FAIL ab1_strobes got %b/%b exp 0/0", wr_strobe, rd_strobe); end
    checks++; if (reg_flat[7:0] !== 8'h11) begin errors++; $display("FAIL ab1_reg0 got %h exp 11", reg_flat[7:0]); end
    $display("abort after setup: reg0=%h", reg_flat[7:0]);
`ifdef BUSINT_WAIT_EN
    // Abort 2: PSEL dropped after the first (waiting) PENABLE cycle.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 4'd0; pwrite = 1'b1; pwdata = 8'h99;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL ab2_wait_pready got %b exp 0", pready); end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({wr_strobe, rd_strobe} !== 8'h00) begin errors++; $display("FAIL ab2_strobes got %b/%b exp 0/0", wr_strobe, rd_strobe); end
    checks++; if (reg_flat[7:0] !== 8'h11) begin errors++; $display("FAIL ab2_reg0 got %h exp 11", reg_flat[7:0]); end
    $display("abort during wait: reg0=%h", reg_flat[7:0]);
`endif
  endtask

  task automatic test_back_to_back();
    int waits; logic err; logic [7:0] rd;
    do_xfer(4'd2, 1'b1, 8'h55, waits, err, rd);
    model_regs[2] = 8'h55;
    checks++; if (waits !== EXP_WAIT) begin errors++; $display("FAIL b2b_wr_waits got %0d exp %0d", waits, EXP_WAIT); end
    do_xfer(4'd2, 1'b0, 8'h00, waits, err, rd);
    checks++; if (waits !== EXP_WAIT) begin errors++; $display("FAIL b2b_rd_waits got %0d exp %0d", waits, EXP_WAIT); end
    checks++; if (rd !== 8'h55) begin errors++; $display("FAIL b2b_rdata got %h exp 55", rd); end
    release_bus();
    checks++; if (rd_strobe !== 4'b0100 || wr_strobe !== 4'b0000) begin errors++; $display("FAIL b2b_strobe got %b/%b exp 0000/0100", wr_strobe, rd_strobe); end
    $display("back-to-back write/read addr=2 rdata=%h", rd);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 4'd3; pwrite = 1'b1; pwdata = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1; srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    for (int k = 0; k < 4; k++) model_regs[k] = '0;
    @(negedge clk);
    checks++; if (reg_flat[31:24] !== 8'h00) begin errors++; $display("FAIL rstmid_reg3 got %h exp 00", reg_flat[31:24]); end
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready got %b exp 0", pready); end
    checks++; if ({wr_strobe, rd_strobe} !== 8'h00) begin errors++; $display("FAIL rstmid_strobes got %b/%b exp 0/0", wr_strobe, rd_strobe); end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++; if (reg_flat !== model_flat()) begin errors++; $display("FAIL rstmid_regflat got %h exp %h", reg_flat, model_flat()); end
    $display("reset mid-access: regflat=%h", reg_flat);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
